// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Optional feature macro used by the arbiter: DMEM_ARB_RR_EN (round-robin policy).
package dmem_arb_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_STRB_W = 4;
  // Request bundles carry a full-width address so range checks work for any DEPTH/AW pair.
  localparam int DMEM_ADDR_W = 32;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_id_e;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_DATA_W-1:0] wdata;
    logic [DMEM_STRB_W-1:0] wstrb;
  } dmem_req_t;

  function automatic logic addr_in_range(input logic [DMEM_ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return addr < DMEM_ADDR_W'(depth);
  endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// Grant decision for the two memory requesters, with starvation counter or round-robin pointer.
// DMEM_ARB_RR_EN selects round-robin; otherwise CPU-priority with a bounded wait for port 1.
module dmem_arb_grant
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic gnt0, gnt1;

`ifdef DMEM_ARB_RR_EN
  port_id_e rr_ptr_q, rr_ptr_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt0     = req0_i & (~req1_i | (rr_ptr_q == PORT_CPU));
    gnt1     = req1_i & ~gnt0;
    rr_ptr_d = rr_ptr_q;
    if (req0_i && req1_i) begin
      rr_ptr_d = (rr_ptr_q == PORT_CPU) ? PORT_DBG : PORT_CPU;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= PORT_CPU;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt1       = req1_i & (~req0_i | (wait_cnt_q == MAX_WAIT_C));
    gnt0       = req0_i & ~gnt1;
    wait_cnt_d = wait_cnt_q;
    if (!req1_i || gnt1) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Grants are combinational, so they are masked while reset is asserted.
  assign gnt0_o = gnt0 & rst_n;
  assign gnt1_o = gnt1 & rst_n;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory (CPU + UART bridge).
// Build with DMEM_ARB_RR_EN for round-robin arbitration instead of CPU-priority.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [AW-1:0]          m0_addr,
  input  logic [DMEM_DATA_W-1:0] m0_wdata,
  input  logic [DMEM_STRB_W-1:0] m0_wstrb,
  output logic                   m0_gnt,
  output logic                   m0_rvalid,
  output logic [DMEM_DATA_W-1:0] m0_rdata,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [AW-1:0]          m1_addr,
  input  logic [DMEM_DATA_W-1:0] m1_wdata,
  input  logic [DMEM_STRB_W-1:0] m1_wstrb,
  output logic                   m1_gnt,
  output logic                   m1_rvalid,
  output logic [DMEM_DATA_W-1:0] m1_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [AW-1:0]          mem_addr,
  output logic [DMEM_DATA_W-1:0] mem_wdata,
  output logic [DMEM_STRB_W-1:0] mem_wstrb,
  input  logic [DMEM_DATA_W-1:0] mem_rdata,
  output logic                   conflict
);

  dmem_req_t req0, req1, sel;
  logic      any_gnt, in_range;
  logic      rsp_valid_q, rsp_valid_d;
  port_id_e  rsp_owner_q, rsp_owner_d;
  logic      rsp_oor_q, rsp_oor_d;
  logic      conflict_q;
  logic [DMEM_DATA_W-1:0] rsp_data;

  assign req0 = '{we: m0_we, addr: DMEM_ADDR_W'(m0_addr), wdata: m0_wdata, wstrb: m0_wstrb};
  assign req1 = '{we: m1_we, addr: DMEM_ADDR_W'(m1_addr), wdata: m1_wdata, wstrb: m1_wstrb};

  dmem_arb_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .gnt0_o (m0_gnt),
    .gnt1_o (m1_gnt)
  );

  always_comb begin
    sel         = m1_gnt ? req1 : req0;
    any_gnt     = m0_gnt | m1_gnt;
    in_range    = addr_in_range(sel.addr, DEPTH);
    // Out-of-range accesses are granted and answered, but never reach the memory.
    mem_en      = any_gnt & in_range;
    mem_we      = any_gnt & in_range & sel.we;
    mem_addr    = any_gnt ? sel.addr[AW-1:0] : '0;
    mem_wdata   = any_gnt ? sel.wdata : '0;
    mem_wstrb   = any_gnt ? sel.wstrb : '0;
    rsp_valid_d = any_gnt & ~sel.we;
    rsp_owner_d = m1_gnt ? PORT_DBG : PORT_CPU;
    rsp_oor_d   = ~in_range;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= PORT_CPU;
      rsp_oor_q   <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      rsp_oor_q   <= rsp_oor_d;
      conflict_q  <= m0_req & m1_req;
    end
  end

  assign rsp_data  = rsp_oor_q ? '0 : mem_rdata;
  assign m0_rvalid = rsp_valid_q & (rsp_owner_q == PORT_CPU);
  assign m1_rvalid = rsp_valid_q & (rsp_owner_q == PORT_DBG);
  assign m0_rdata  = m0_rvalid ? rsp_data : '0;
  assign m1_rdata  = m1_rvalid ? rsp_data : '0;
  assign conflict  = conflict_q;

  // A refused requester must keep its request and fields unchanged.
  a_m0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m0_req && !m0_gnt) |=> (m0_req && $stable(req0)));
  a_m1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (m1_req && !m1_gnt) |=> (m1_req && $stable(req1)));
  a_one_gnt: assert property (@(posedge clk) !(m0_gnt && m1_gnt));

endmodule
